// File: rtl/acc_addsub_pkg.sv
// Shared definitions for the add/subtract/accumulate unit: beat modes and the
// accepted-beat counter that sticks at its maximum.
package acc_addsub_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ACC = 2'd2,
    MODE_CLR = 2'd3
  } mode_e;

  localparam int OPS_WIDTH = 8;
  localparam logic [OPS_WIDTH-1:0] OPS_MAX = OPS_WIDTH'(255);

  function automatic logic [OPS_WIDTH-1:0] ops_inc(input logic [OPS_WIDTH-1:0] n);
    return (n == OPS_MAX) ? n : n + OPS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/acc_addsub_unit_if.sv
// Operand/result bus of acc_addsub_unit: valid/ready input beat and a
// valid/ready output stage carrying result, accumulator, flag and beat count.
interface acc_addsub_unit_if
  import acc_addsub_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  mode_e                mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [ACC_WIDTH-1:0] acc;
  logic                 flag_c;
  logic [OPS_WIDTH-1:0] ops;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, acc, flag_c, ops
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, acc, flag_c, ops
  );
endinterface

// File: rtl/sat_addsub.sv
// Combinational W-bit unsigned add/subtract with carry/borrow flag and an
// optional clamp to all-ones (add overflow) or zero (subtract underflow).
module sat_addsub #(
  parameter int W        = 8,
  parameter int SATURATE = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         flag
);
  logic [W:0] raw;

  // NOTE: every output gets a value before any branch so no latch is inferred.
  always_comb begin
    raw  = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    flag = raw[W];
    sum  = raw[W-1:0];
    if ((SATURATE != 0) && flag) begin
      sum = sub ? '0 : '1;
    end
  end
endmodule

// File: rtl/acc_addsub_unit.sv
// Add/subtract/accumulate unit with a single registered valid/ready output
// stage; holds result, acc and flag while the consumer stalls.
module acc_addsub_unit
  import acc_addsub_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 1
) (
  input logic              clk,
  input logic              rst,
  acc_addsub_unit_if.slave bus
);
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 flag_q, flag_d;
  logic [OPS_WIDTH-1:0] ops_q;
  logic                 in_ready;
  logic                 accept;

  logic [WIDTH-1:0]     op_sum;
  logic                 op_flag;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_flag;

  // Ready is not gated by rst; a beat accepted during reset is simply dropped.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  sat_addsub #(.W(WIDTH), .SATURATE(SATURATE)) u_op (
    .x    (bus.a),
    .y    (bus.b),
    .sub  (bus.mode == MODE_SUB),
    .sum  (op_sum),
    .flag (op_flag)
  );

  sat_addsub #(.W(ACC_WIDTH), .SATURATE(SATURATE)) u_acc (
    .x    (ACC_WIDTH'(bus.a)),
    .y    (acc_q),
    .sub  (1'b0),
    .sum  (acc_sum),
    .flag (acc_flag)
  );

  always_comb begin
    result_d = op_sum;
    acc_d    = acc_q;
    flag_d   = op_flag;
    case (bus.mode)
      MODE_ACC: begin
        acc_d    = acc_sum;
        flag_d   = acc_flag;
        result_d = acc_sum[WIDTH-1:0];
      end
      MODE_CLR: begin
        acc_d    = '0;
        result_d = '0;
        flag_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      ops_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      ops_q       <= ops_inc(ops_q);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.acc       = acc_q;
  assign bus.flag_c    = flag_q;
  assign bus.ops       = ops_q;
endmodule

// File: tb/tb_acc_addsub_unit.sv
// Drives a saturating and a wrapping instance with identical beats and checks
// both against an integer-arithmetic reference model every cycle.
module tb_acc_addsub_unit;
  import acc_addsub_pkg::*;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 16;
  localparam longint LIM_W = 64'd1 << WIDTH;
  localparam longint LIM_A = 64'd1 << ACC_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acc_addsub_unit_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus_s ();
  acc_addsub_unit_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus_w ();

  acc_addsub_unit #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .SATURATE(1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  acc_addsub_unit #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .SATURATE(0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  // Reference model: index 0 = saturating instance, 1 = wrapping instance.
  typedef struct {
    longint result;
    longint acc;
    bit     flag;
  } exp_t;

  exp_t m[2];
  bit   m_valid;
  bit   m_known = 1'b0;
  int   m_ops;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_known = 1'b1;
    m_valid = 1'b0;
    m_ops   = 0;
    for (int k = 0; k < 2; k++) begin
      m[k].result = 0;
      m[k].acc    = 0;
      m[k].flag   = 1'b0;
    end
  endtask

  task automatic model_beat(input longint ia, input longint ib, input mode_e md);
    longint s;
    bit     sat;
    for (int k = 0; k < 2; k++) begin
      sat = (k == 0);
      case (md)
        MODE_ADD: begin
          s           = ia + ib;
          m[k].flag   = (s >= LIM_W);
          m[k].result = (m[k].flag && sat) ? LIM_W - 1 : s % LIM_W;
        end
        MODE_SUB: begin
          m[k].flag = (ia < ib);
          if (!m[k].flag)  m[k].result = ia - ib;
          else if (sat)    m[k].result = 0;
          else             m[k].result = ia + LIM_W - ib;
        end
        MODE_ACC: begin
          s         = m[k].acc + ia;
          m[k].flag = (s >= LIM_A);
          if (!m[k].flag)  m[k].acc = s;
          else if (sat)    m[k].acc = LIM_A - 1;
          else             m[k].acc = s - LIM_A;
          m[k].result = m[k].acc % LIM_W;
        end
        default: begin
          m[k].acc    = 0;
          m[k].result = 0;
          m[k].flag   = 1'b0;
        end
      endcase
    end
    m_valid = 1'b1;
    if (m_ops < 255) m_ops++;
  endtask

  task automatic check_dut(input string name, input logic ov, input logic [WIDTH-1:0] res,
                           input logic [ACC_WIDTH-1:0] acc, input logic flg,
                           input logic [OPS_WIDTH-1:0] ops, input int k);
    check({name, ".out_valid"}, ov, m_valid);
    check({name, ".result"}, res, m[k].result);
    check({name, ".acc"}, acc, m[k].acc);
    check({name, ".flag_c"}, flg, m[k].flag);
    check({name, ".ops"}, ops, m_ops);
  endtask

  // One clock cycle: drive at the falling edge, check ready before the rising
  // edge, then check registered outputs 1 time unit after it.
  task automatic cycle(input bit v, input int ia, input int ib, input mode_e md,
                       input bit r, input bit do_rst = 1'b0);
    bit exp_rdy;
    bit acc_now;
    @(negedge clk);
    rst             = do_rst;
    bus_s.in_valid  = v;
    bus_w.in_valid  = v;
    bus_s.a         = WIDTH'(ia);
    bus_w.a         = WIDTH'(ia);
    bus_s.b         = WIDTH'(ib);
    bus_w.b         = WIDTH'(ib);
    bus_s.mode      = md;
    bus_w.mode      = md;
    bus_s.out_ready = r;
    bus_w.out_ready = r;
    #1;
    exp_rdy = !m_valid || r;
    if (m_known) begin
      check("sat.in_ready", bus_s.in_ready, exp_rdy);
      check("wrap.in_ready", bus_w.in_ready, exp_rdy);
    end
    acc_now = v && exp_rdy;
    @(posedge clk);
    #1;
    if (do_rst)       model_reset();
    else if (acc_now) model_beat(ia, ib, md);
    else if (r)       m_valid = 1'b0;
    check_dut("sat", bus_s.out_valid, bus_s.result, bus_s.acc, bus_s.flag_c, bus_s.ops, 0);
    check_dut("wrap", bus_w.out_valid, bus_w.result, bus_w.acc, bus_w.flag_c, bus_w.ops, 1);
  endtask

  initial begin
    // Reset and idle
    cycle(1'b0, 0, 0, MODE_ADD, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, MODE_ADD, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, MODE_ADD, 1'b1);

    // ADD overflow and plain ADD
    cycle(1'b1, 200, 100, MODE_ADD, 1'b1);
    check("tp1.sat_add_clamp", bus_s.result, 255);
    check("tp1.sat_add_flag", bus_s.flag_c, 1);
    check("tp2.wrap_add", bus_w.result, 44);
    cycle(1'b1, 20, 30, MODE_ADD, 1'b1);
    check("tp1.add_plain", bus_s.result, 50);
    check("tp1.add_noflag", bus_s.flag_c, 0);

    // SUB underflow
    cycle(1'b1, 10, 20, MODE_SUB, 1'b1);
    check("tp2.sat_sub_clamp", bus_s.result, 0);
    check("tp2.wrap_sub", bus_w.result, 246);
    check("tp2.sub_borrow", bus_w.flag_c, 1);

    // Backpressure: held beat ignored until out_ready rises
    cycle(1'b1, 5, 6, MODE_ADD, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 7, 8, MODE_SUB, 1'b0);
    check("tp3.frozen_result", bus_s.result, 11);
    cycle(1'b1, 7, 8, MODE_ADD, 1'b1);
    check("tp3.resumed_result", bus_s.result, 15);

    // Long accumulate into saturation / wrap
    cycle(1'b0, 0, 0, MODE_ADD, 1'b1, 1'b1);
    cycle(1'b1, 0, 0, MODE_CLR, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 255, $urandom_range(0, 255), MODE_ACC, 1'b1);
    check("tp4.sat_acc", bus_s.acc, 65535);
    check("tp4.sat_flag", bus_s.flag_c, 1);
    check("tp4.sat_result", bus_s.result, 255);
    check("tp4.ops_hold", bus_s.ops, 255);
    check("tp4.wrap_acc", bus_w.acc, 10964);
    check("tp4.wrap_result", bus_w.result, 212);

    // Back-to-back random ADD/SUB at full throughput
    for (int i = 0; i < 100; i++)
      cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
            mode_e'($urandom_range(0, 1)), 1'b1);
    check("tp5.stream_valid", bus_s.out_valid, 1);

    // Random mix of all modes with random valid/ready
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255),
            mode_e'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));

    // Reset mid-stream over a simultaneous accept
    cycle(1'b1, 0, 0, MODE_CLR, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 250, 0, MODE_ACC, 1'b1);
    check("tp6.acc_1000", bus_s.acc, 1000);
    cycle(1'b1, 9, 9, MODE_ACC, 1'b1, 1'b1);
    check("tp6.rst_valid", bus_s.out_valid, 0);
    check("tp6.rst_acc", bus_s.acc, 0);
    check("tp6.rst_ops", bus_s.ops, 0);
    cycle(1'b1, 5, 0, MODE_ACC, 1'b1);
    check("tp6.acc_5", bus_s.acc, 5);
    check("tp6.wrap_acc_5", bus_w.acc, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
